// File: rtl/shift_reg_seq.sv
// Sequenced WIDTH-bit shift register with parallel load.
// Runs multi-step shift/rotate sequences with a busy/done handshake.
module shift_reg_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amount,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CNT_W-1:0] ZERO = '0;
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]       state;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       mode_l;
   logic [2:0]       step_mode;
   logic [WIDTH-1:0] nq;
   logic             nout;

   // Reserved modes fall through the default and leave q/sout untouched.
   always_comb begin
      step_mode = (state == SHIFT) ? mode_l : mode;
      nq        = q;
      nout      = sout;
      case (step_mode)
         3'b000: begin
            nq   = {q[WIDTH-2:0], sin};
            nout = q[WIDTH-1];
         end
         3'b001: begin
            nq   = {sin, q[WIDTH-1:1]};
            nout = q[0];
         end
         3'b010: begin
            nq   = {q[WIDTH-2:0], q[WIDTH-1]};
            nout = q[WIDTH-1];
         end
         3'b011: begin
            nq   = {q[0], q[WIDTH-1:1]};
            nout = q[0];
         end
         3'b100: begin
            nq   = {q[WIDTH-1], q[WIDTH-1:1]};
            nout = q[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q         <= '0;
         sout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         state     <= IDLE;
         remaining <= '0;
         mode_l    <= 3'b000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  q <= d;
               end else if (start) begin
                  if (amount == ZERO) begin
                     done <= 1'b1;
                  end else begin
                     q    <= nq;
                     sout <= nout;
                     if (amount == ONE) begin
                        done <= 1'b1;
                     end else begin
                        remaining <= amount - ONE;
                        mode_l    <= mode;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                     end
                  end
               end
            end
            SHIFT: begin
               q         <= nq;
               sout      <= nout;
               remaining <= remaining - ONE;
               if (remaining == ONE) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed scenarios plus
// randomized sequences against an arithmetic reference model.
module tb_shift_reg_seq;

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] d;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amount;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   int mq   = 0;
   bit mout = 1'b0;

   shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .d      (d),
      .start  (start),
      .mode   (mode),
      .amount (amount),
      .sin    (sin),
      .q      (q),
      .sout   (sout),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One step as plain arithmetic on an 8-bit unsigned value.
   task automatic model_step(input logic [2:0] m, input logic s);
      int v;
      int b;
      v = mq;
      b = s ? 1 : 0;
      case (m)
         3'd0: begin mout = (v >= 128); mq = (v * 2) % 256 + b; end
         3'd1: begin mout = (v % 2) != 0; mq = v / 2 + b * 128; end
         3'd2: begin mout = (v >= 128); mq = (v * 2) % 256 + v / 128; end
         3'd3: begin mout = (v % 2) != 0; mq = v / 2 + (v % 2) * 128; end
         3'd4: begin mout = (v % 2) != 0; mq = v / 2 + (v / 128) * 128; end
         default: ;
      endcase
   endtask

   task automatic do_load(input logic [7:0] v);
      @(negedge clk);
      load = 1'b1;
      d    = v;
      @(posedge clk);
      #1;
      load = 1'b0;
      mq   = v;
      checks++;
      if (q !== v || sout !== mout || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL load q=%h sout=%b busy=%b done=%b exp q=%h sout=%b busy=0 done=0",
                  q, sout, busy, done, v, mout);
      end
   endtask

   task automatic run_seq(input logic [2:0] m, input logic [3:0] n,
                          input logic [15:0] pat, input bit rnd, input bit noise);
      logic s;
      @(negedge clk);
      s      = rnd ? 1'($urandom) : pat[0];
      start  = 1'b1;
      mode   = m;
      amount = n;
      sin    = s;
      if (n != 4'd0) model_step(m, s);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 1; k < int'(n); k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL seq_busy step=%0d busy=%b done=%b exp busy=1 done=0",
                     k, busy, done);
         end
         s   = rnd ? 1'($urandom) : pat[k];
         sin = s;
         if (noise) begin
            load   = 1'($urandom);
            d      = 8'($urandom);
            mode   = 3'($urandom);
            amount = 4'($urandom);
            start  = 1'($urandom);
         end
         model_step(m, s);
         @(posedge clk);
         #1;
      end
      load  = 1'b0;
      start = 1'b0;
      checks++;
      if (q !== 8'(mq) || sout !== mout || busy !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL seq_end mode=%0d n=%0d q=%h sout=%b busy=%b done=%b exp q=%h sout=%b busy=0 done=1",
                  m, n, q, sout, busy, done, 8'(mq), mout);
      end
   endtask

   task automatic check_idle(input string name);
      @(posedge clk);
      #1;
      checks++;
      if (q !== 8'(mq) || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s q=%h busy=%b done=%b exp q=%h busy=0 done=0",
                  name, q, busy, done, 8'(mq));
      end
   endtask

   task automatic check_q(input string name, input logic [7:0] eq, input logic es);
      checks++;
      if (q !== eq || sout !== es) begin
         failures++;
         $display("FAIL %s q=%h sout=%b exp q=%h sout=%b", name, q, sout, eq, es);
      end
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      load = 1'b1;
      d    = 8'hA5;
      #12;
      checks++;
      if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset q=%h sout=%b busy=%b done=%b exp 00/0/0/0",
                  q, sout, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      load = 1'b0;
      mq   = 8'hA5;
      mout = 1'b0;
      check_q("reset_load", 8'hA5, 1'b0);
   endtask

   task automatic test_shl;
      run_seq(3'd0, 4'd3, 16'h0000, 1'b0, 1'b0);
      check_q("shl3", 8'h28, 1'b1);
      check_idle("shl_done_clear");
   endtask

   task automatic test_ror_wrap;
      do_load(8'h81);
      run_seq(3'd3, 4'd9, 16'h0000, 1'b0, 1'b1);
      check_q("ror9", 8'hC0, 1'b1);
   endtask

   task automatic test_back_to_back;
      do_load(8'h90);
      run_seq(3'd4, 4'd2, 16'h0000, 1'b0, 1'b0);
      check_q("asr2", 8'hE4, 1'b0);
      run_seq(3'd1, 4'd0, 16'h0000, 1'b0, 1'b0);
      check_q("zero_amount", 8'hE4, 1'b0);
      check_idle("zero_done_clear");
   endtask

   task automatic test_shr_reserved;
      do_load(8'h00);
      run_seq(3'd1, 4'd4, 16'h0003, 1'b0, 1'b0);
      check_q("shr4", 8'h30, 1'b0);
      run_seq(3'd7, 4'd3, 16'h0000, 1'b1, 1'b0);
      check_q("reserved", 8'h30, 1'b0);
   endtask

   task automatic test_async_reset;
      do_load(8'h3C);
      @(negedge clk);
      start  = 1'b1;
      mode   = 3'd2;
      amount = 4'd6;
      sin    = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset q=%h sout=%b busy=%b done=%b exp 00/0/0/0",
                  q, sout, busy, done);
      end
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b0;
      mq   = 0;
      mout = 1'b0;
      for (int k = 0; k < 6; k++) check_idle("no_done_after_reset");
      do_load(8'h5A);
      run_seq(3'd0, 4'd5, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(2) == 0) do_load(8'($urandom));
         run_seq(3'($urandom), 4'($urandom), 16'h0000, 1'b1, 1'($urandom));
         if ($urandom_range(3) == 0) check_idle("rand_done_clear");
      end
   endtask

   initial begin
      rst    = 1'b1;
      load   = 1'b0;
      d      = 8'h00;
      start  = 1'b0;
      mode   = 3'd0;
      amount = 4'd0;
      sin    = 1'b0;
      test_reset();
      test_shl();
      test_ror_wrap();
      test_back_to_back();
      test_shr_reserved();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
Parametrised sequenced shift register. It is the next generation of the team's single-bit storage cells (D latch / D flip-flop), generalised to a WIDTH-bit edge-triggered register with parallel load. It adds a multi-step shift/rotate engine with a busy/done handshake. It is used as the data-path register for serial/parallel conversion in the lab exercises.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of the shift-amount input and the internal remaining-step counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
load  input  1  parallel load request (accepted only when idle)
d  input  WIDTH  parallel load data
start  input  1  start a sequenced shift (accepted only when idle)
mode  input  3  shift operation, sampled with start
amount  input  CNT_W  number of single-bit steps, sampled with start
sin  input  1  serial fill bit for SHL/SHR, sampled at every step
q  output  WIDTH  register contents
sout  output  1  registered bit shifted/rotated out by the most recent step
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, no clock edge needed): q=0, sout=0, busy=0, done=0, FSM=IDLE, remaining count=0, latched mode=0. Reset mid-sequence aborts it; no done pulse follows.
- FSM states: IDLE, SHIFT.
- Modes (one step):
  - 000 SHL: q<={q[W-2:0],sin}, out=q[W-1]
  - 001 SHR: q<={sin,q[W-1:1]}, out=q[0]
  - 010 ROL: out=q[W-1]
  - 011 ROR: out=q[0]
  - 100 ASR: fill with q[W-1], out=q[0]
  - 101-111 reserved: q and sout hold, steps are still counted.
- IDLE priority: load over start.
  - load=1: q<=d; sout unchanged; done<=0.
- IDLE, start=1, load=0, amount=N:
  - N=0: q unchanged, done<=1 for one cycle, busy stays 0.
  - N=1: one step at this edge, done<=1, stay IDLE.
  - N>1: one step at this edge, remaining<=N-1, mode latched, busy<=1, go to SHIFT.
- SHIFT, each edge: one step with the latched mode, remaining decremented.
  - At the edge where remaining==1: busy<=0, done<=1, go to IDLE.
- Timing: N steps occupy N consecutive edges starting with the start edge. busy is high for N-1 cycles. done is high for exactly the one cycle after the last step.
- load, start, mode and amount are ignored while busy. mode/amount changes mid-sequence have no effect.
- start sampled during the done cycle (FSM in IDLE) is accepted: back-to-back sequences run with no gap.
- done is cleared on every edge where it is not re-asserted.
- amount > WIDTH is legal: exactly amount steps are performed. Rotates wrap; shifts fully flush.
- sin is sampled live at each step, not latched at start.

Test Plan:
1. rst=1 then release; load=1 d=8'hA5 -> q=00/busy=0/done=0 during reset; q=A5 after next edge, sout=0.
2. From A5: start mode=000 amount=3 sin=0 -> q=28 after 3rd edge, sout=1, busy high 2 cycles, done high 1 cycle then 0.
3. load 8'h81; start mode=011 amount=9 -> q=C0, sout=1, done 9 cycles after start edge. Assert load=1 d=FF while busy -> ignored.
4. load 8'h90; start mode=100 amount=2 -> q=E4, sout=0. Then start amount=0 during the done cycle -> q stays E4, busy never rises, done high one more cycle.
5. load 8'h00; start mode=001 amount=4, sin=1 for two steps then 0 -> q=30, sout=0. Then start mode=111 amount=3 -> q holds 30, done after 3 cycles.
6. load 8'h3C; start mode=010 amount=6; assert rst asynchronously between edges after 2 steps -> q=00, busy=0 immediately, no done pulse, next start/load accepted normally.
